// File: rtl/vga_scan_ctrl.sv
// Raster scan sequencer: pixel divider, x/y counters, sync/enable decode and frame-aligned mode register.
// Optional MODE_CYCLE_EN adds a synchronised pushbutton (i_btn_mode) that steps to the next mode.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode_sel,
  input  logic       i_mode_sel_valid,
`ifdef MODE_CYCLE_EN
  input  logic       i_btn_mode,
`endif
  output logic       o_pix_tick,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_enable,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_frame_start,
  output logic [1:0] o_mode,
  output logic       o_mode_pending
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_pix_tick;
  logic             r_enable;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_frame_start;
  logic [1:0]       r_mode;
  logic [1:0]       r_pend_val;
  logic             r_pending;

  logic             w_adv;
  logic             w_x_wrap;
  logic             w_wrap;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;
  logic             w_req;
  logic [1:0]       w_req_mode;

  always_comb begin
    w_adv    = (r_div_cnt == DIV_LAST);
    w_x_wrap = (r_x == X_LAST);
    w_wrap   = w_adv && w_x_wrap && (r_y == Y_LAST);
    w_x_nxt  = r_x;
    w_y_nxt  = r_y;
    if (w_adv) begin
      if (w_x_wrap) begin
        w_x_nxt = '0;
        w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + 10'd1;
      end else begin
        w_x_nxt = r_x + 10'd1;
      end
    end
  end

  // Decode from next-state counters so sync/enable line up with x/y on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt     <= '0;
      r_x           <= X_LAST;
      r_y           <= Y_LAST;
      r_pix_tick    <= 1'b0;
      r_enable      <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt     <= w_adv ? '0 : r_div_cnt + DIV_W'(1);
      r_pix_tick    <= w_adv;
      r_frame_start <= w_wrap;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_enable      <= (w_x_nxt < X_ACT) && (w_y_nxt < Y_ACT);
      r_hsync       <= !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
      r_vsync       <= !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
    end
  end

`ifdef MODE_CYCLE_EN
  logic       r_btn_meta;
  logic       r_btn_sync;
  logic       r_btn_prev;
  logic       w_btn_rise;
  logic [1:0] w_cycle_base;
  logic [1:0] w_cycle_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= i_btn_mode;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  // Step from whatever will be live next frame, so repeated presses keep advancing.
  always_comb begin
    w_btn_rise   = r_btn_sync && !r_btn_prev;
    w_cycle_base = r_pending ? r_pend_val : r_mode;
    case (w_cycle_base)
      2'b00:   w_cycle_next = 2'b01;
      2'b01:   w_cycle_next = 2'b10;
      default: w_cycle_next = 2'b00;
    endcase
  end
`endif

  always_comb begin
    w_req      = 1'b0;
    w_req_mode = r_pend_val;
`ifdef MODE_CYCLE_EN
    if (w_btn_rise) begin
      w_req      = 1'b1;
      w_req_mode = w_cycle_next;
    end
`endif
    if (i_mode_sel_valid) begin
      w_req      = 1'b1;
      w_req_mode = (i_mode_sel == 2'b11) ? 2'b10 : i_mode_sel;
    end
  end

  // A request landing on the wrap edge is kept for the following frame, not applied now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= 2'b00;
      r_pend_val <= 2'b00;
      r_pending  <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_mode <= r_pend_val;
      end
      if (w_req) begin
        r_pend_val <= w_req_mode;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign o_pix_tick     = r_pix_tick;
  assign o_x            = r_x;
  assign o_y            = r_y;
  assign o_enable       = r_enable;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_frame_start  = r_frame_start;
  assign o_mode         = r_mode;
  assign o_mode_pending = r_pending;

endmodule
